breath_led_array: RTL

//  Parametrised N-channel breathing-LED driver: one shared PWM carrier plus one duty ramp

---
 rtl/breath_pkg.sv | 11 +
 rtl/breath_ramp_gen.sv | 87 ++++++++
 rtl/breath_led_array.sv | 73 +++++++
 3 files changed

// File: rtl/breath_pkg.sv
// Shared encodings for the breathing-LED array: mode select values and per-channel phases.
package breath_pkg;

  localparam logic [1:0] MODE_ROTATE = 2'd0;
  localparam logic [1:0] MODE_SYNC   = 2'd1;
  localparam logic [1:0] MODE_HOLD   = 2'd2;

  localparam int unsigned PH_RISE = 0;
  localparam int unsigned PH_FALL = 1;

endpackage

// File: rtl/breath_ramp_gen.sv
// Shared timing core: PWM carrier counter, step divider, duty ramp, phase sequence and
// latched mode, plus the registered ramp-completion pulse.
module breath_ramp_gen
  import breath_pkg::*;
#(
  parameter int unsigned N_CH     = 3,
  parameter int unsigned PERIOD   = 2400,
  parameter int unsigned STEP_DIV = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic [1:0]                mode,
  output logic [$clog2(PERIOD)-1:0] cnt_pwm,
  output logic [$clog2(PERIOD)-1:0] duty,
  output logic [$clog2(N_CH)-1:0]   seq,
  output logic                      sync,
  output logic                      ramp_done
);

  localparam int unsigned CW = $clog2(PERIOD);
  localparam int unsigned DW = $clog2(STEP_DIV) + 1;
  localparam int unsigned SW = $clog2(N_CH);

  localparam logic [CW-1:0] LAST     = CW'(PERIOD - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(STEP_DIV - 1);
  localparam logic [SW-1:0] SEQ_LAST = SW'(N_CH - 1);

  logic [CW-1:0] cnt_q, cnt_d, duty_q, duty_d;
  logic [DW-1:0] div_q, div_d;
  logic [SW-1:0] seq_q, seq_d;
  logic          sync_q, sync_d, done_q, done_d;
  logic          hold, tick, step, wrap;

  assign hold = (mode == MODE_HOLD);
  assign tick = (cnt_q == LAST);
  assign step = tick && (div_q == DIV_LAST) && !hold;
  assign wrap = step && (duty_q == LAST);

  always_comb begin
    cnt_d  = cnt_q;
    div_d  = div_q;
    duty_d = duty_q;
    seq_d  = seq_q;
    sync_d = sync_q;
    done_d = en && wrap;
    if (en) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
      if (tick && !hold) div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
      if (step) duty_d = wrap ? '0 : duty_q + 1'b1;
      if (wrap) begin
        if (sync_q) seq_d = (seq_q == '0) ? SW'(1) : '0;
        else        seq_d = (seq_q == SEQ_LAST) ? '0 : seq_q + 1'b1;
      end
    end
    // HOLD never reaches mode_q; the reserved code behaves as ROTATE
    if (!en || wrap) begin
      if (mode == MODE_SYNC)      sync_d = 1'b1;
      else if (mode != MODE_HOLD) sync_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      div_q  <= '0;
      duty_q <= '0;
      seq_q  <= '0;
      sync_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      div_q  <= div_d;
      duty_q <= duty_d;
      seq_q  <= seq_d;
      sync_q <= sync_d;
      done_q <= done_d;
    end
  end

  assign cnt_pwm   = cnt_q;
  assign duty      = duty_q;
  assign seq       = seq_q;
  assign sync      = sync_q;
  assign ramp_done = done_q;

endmodule

// File: rtl/breath_led_array.sv
// N-channel breathing-LED driver: maps the shared ramp onto per-channel phases and drives
// registered PWM pins with selectable polarity.
module breath_led_array
  import breath_pkg::*;
#(
  parameter int unsigned N_CH       = 3,
  parameter int unsigned PERIOD     = 2400,
  parameter int unsigned STEP_DIV   = 1,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    EN,
  input  logic [1:0]              MODE,
  output logic [N_CH-1:0]         LED,
  output logic                    RAMP_DONE,
  output logic [$clog2(N_CH)-1:0] SEQ
);

  localparam int unsigned CW = $clog2(PERIOD);
  localparam int unsigned SW = $clog2(N_CH);
  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);
  localparam logic [N_CH-1:0] DARK = {N_CH{ACTIVE_LOW}};

  logic [CW-1:0]   cnt_pwm, duty, fall_lim;
  logic [SW-1:0]   seq;
  logic            sync;
  logic [N_CH-1:0] lit, led_q;

  breath_ramp_gen #(
    .N_CH     (N_CH),
    .PERIOD   (PERIOD),
    .STEP_DIV (STEP_DIV)
  ) u_ramp (
    .clk       (CLK),
    .rst_n     (RST_N),
    .en        (EN),
    .mode      (MODE),
    .cnt_pwm   (cnt_pwm),
    .duty      (duty),
    .seq       (seq),
    .sync      (sync),
    .ramp_done (RAMP_DONE)
  );

  assign fall_lim = LAST - duty;

  for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
    logic [SW:0] ph;

    // (seq + N_CH - ch) mod N_CH, folded by compare since seq < N_CH
    always_comb begin
      if (sync || ch == 0)                   ph = {1'b0, seq};
      else if ({1'b0, seq} >= (SW+1)'(ch))   ph = {1'b0, seq} - (SW+1)'(ch);
      else                                   ph = {1'b0, seq} + (SW+1)'(N_CH - ch);
    end

    always_comb begin
      if (ph == (SW+1)'(PH_RISE))      lit[ch] = (cnt_pwm < duty);
      else if (ph == (SW+1)'(PH_FALL)) lit[ch] = (cnt_pwm < fall_lim);
      else                             lit[ch] = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N || !EN) led_q <= DARK;
    else               led_q <= ACTIVE_LOW ? ~lit : lit;
  end

  assign LED = led_q;
  assign SEQ = seq;

endmodule
